mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, synchronous-read unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined RV32I core. The block decides each cycle which requester owns the port. It tracks the one outstanding read and routes read data back to its owner. It raises a stall toward whichever stage lost. A streak counter guarantees IF forward progress under back-to-back load/store traffic.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width
- `MAX_D_STREAK`, 3, max consecutive data grants while IF waits (≥1)

- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch read request, held until granted
- `if_addr`  in  ADDR_W  fetch address
- `if_flush`  in  1  redirect: kill IF grant/response this cycle
- `if_gnt`  out  1  fetch accepted this cycle
- `if_stall`  out  1  `if_req & ~if_gnt`
- `if_rvalid`  out  1  fetch data valid
- `if_rdata`  out  DATA_W  fetch data
- `d_req`  in  1  data request, held until granted
- `d_we`  in  1  1 = store, 0 = load
- `d_be`  in  4  byte enables (store)
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data access accepted this cycle
- `d_stall`  out  1  `d_req & ~d_gnt`
- `d_rvalid`  out  1  load data valid
- `d_rdata`  out  DATA_W  load data
- `m_en`, `m_we`  out  1  memory port enable / write
- `m_be`  out  4  memory byte enables
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rdata`  in  DATA_W  memory read data, valid cycle after read enable

## Operation
- Grant logic is combinational from requests, `if_flush`, and `streak`. At most one grant per cycle.
- Priority: data wins by default. IF wins when `if_req & d_req & streak == MAX_D_STREAK`.
- `if_flush=1` masks `if_gnt` in that cycle. Data may then be granted even at max streak.
- `streak`: width `$clog2(MAX_D_STREAK+1)`.
  - Increments on each `d_gnt` while `if_req=1`, saturating at `MAX_D_STREAK`.
  - Clears on `if_gnt` or whenever `if_req=0`.
- Memory mux: the granted requester drives `m_*`.
  - `m_en = if_gnt | d_gnt`.
  - `m_we = d_gnt & d_we`.
  - `m_be = 4'hF` for IF and for loads.
  - With no grant, `m_*` are 0.
- Read-owner register `rd_owner` ∈ {NONE, IF, DATA}. Next value:
  - IF on `if_gnt`.
  - DATA on `d_gnt & ~d_we`.
  - NONE otherwise (stores and idle cycles included).
- Responses:
  - `if_rvalid = (rd_owner==IF) & ~if_flush`.
  - `d_rvalid = (rd_owner==DATA)`.
  - Both rdata outputs pass `m_rdata` through unconditionally; consumers qualify them with rvalid.
- Stores complete at `d_gnt`; no response pulse.

## Timing
- Grant: same cycle as request (0-cycle decision). Read data: exactly 1 cycle after grant.
- Fully pipelined: a new grant may issue in the same cycle as the previous rvalid, giving 1 access/cycle sustained.
- Reset (async, asserted): `rd_owner=NONE`, `streak=0`. Every output is 0 while `rst=1`, with gnts and `m_en` forced low.
- Reset mid-read: the outstanding response is discarded. No rvalid after `rst` deasserts until a new grant.
- Flush in the rvalid cycle: the IF response is dropped. A data response is never affected by `if_flush`.
- `if_flush` and `if_req` in the same cycle: no IF grant. IF is re-arbitrated the next cycle at the new address.
- Streak boundary: with `MAX_D_STREAK=1`, a data grant and an IF grant strictly alternate while both request.

## Structure
- Add to `defines.v`: owner encodings `OWNER_NONE=2'd0`, `OWNER_IF=2'd1`, `OWNER_DATA=2'd2`.
- Natural sub-module: `arb_streak_ctr`, a saturating counter with clear and `at_max` output, parameterised by `MAX_D_STREAK`.
- The rest is flat: the grant/mux combinational block plus the `rd_owner` register.

## Test plan
- **IF only:** `if_req=1`, `if_addr=0x100`, then `0x104`. Required: `if_gnt=1` both cycles; `if_rvalid` the following cycles with the memory contents of `0x100` and `0x104`.
- **Contention:** `if_req=d_req=1` held 5 cycles, loads, MAX=3. Grant sequence must be D, D, D, IF, D.
- **Store:** `d_we=1`, `d_be=4'b0011`, `d_wdata=0xDEADBEEF`, `d_addr=0x200`.
  - Required that cycle: `m_we=1`, `m_be=0011`, no `d_rvalid` next cycle.
  - A subsequent load of `0x200` returns low half `0xBEEF`.
- **Flush:** IF read granted in cycle N, `if_flush=1` in N+1. Required: `if_rvalid=0` in N+1 and `if_gnt=0` in N+1.
- **Reset mid-read:** load granted in N, `rst` pulsed asynchronously mid-N. Required: all outputs 0 immediately; no `d_rvalid` after release.
- **Back-to-back:** load, IF, load in consecutive cycles. Required: `d_rvalid`, `if_rvalid`, `d_rvalid` on the next three cycles, each carrying correct data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    // Owner of the single outstanding read on the memory port.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DATA = 2'd2
    } owner_e;

    localparam logic [3:0] BE_WORD = 4'hF;

    // Stores use the requester's byte lanes; every read is a full word.
    function automatic logic [3:0] sel_be(input logic we, input logic [3:0] be);
        return we ? be : BE_WORD;
    endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating counter of consecutive data grants taken while IF is waiting.
module arb_streak_ctr #(
    parameter int MAX_D_STREAK = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int W = $clog2(MAX_D_STREAK + 1);
    localparam logic [W-1:0] MAX_VAL = W'(MAX_D_STREAK);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority; increment holds once the limit is reached.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_max = (count_q == MAX_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous-read memory port between instruction fetch and
// data access, and steers the single outstanding read response to its owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_stall,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);
    owner_e rd_owner_q;
    owner_e rd_owner_d;
    logic   if_ok;
    logic   at_max;

    arb_streak_ctr #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc   (d_gnt & if_req),
        .clr   (if_gnt | ~if_req),
        .at_max(at_max)
    );

    // Grant decision: data by default, IF once the data streak hits its limit.
    // A flushed fetch never wins, so data may take the port even at the limit.
    always_comb begin
        if_ok    = if_req & ~if_flush;
        d_gnt    = ~rst & d_req & ~(if_ok & at_max);
        if_gnt   = ~rst & if_ok & ~d_gnt;
        if_stall = ~rst & if_req & ~if_gnt;
        d_stall  = ~rst & d_req & ~d_gnt;
    end

    // Memory port mux: the granted requester drives the port, otherwise all zero.
    always_comb begin
        m_en    = if_gnt | d_gnt;
        m_we    = 1'b0;
        m_be    = 4'h0;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_we   = d_we;
            m_be   = sel_be(d_we, d_be);
            m_addr = d_addr;
            if (d_we) begin
                m_wdata = d_wdata;
            end
        end else if (if_gnt) begin
            m_be   = BE_WORD;
            m_addr = if_addr;
        end
    end

    // Next read owner: only reads leave a response pending.
    always_comb begin
        rd_owner_d = OWNER_NONE;
        if (if_gnt) begin
            rd_owner_d = OWNER_IF;
        end else if (d_gnt && !d_we) begin
            rd_owner_d = OWNER_DATA;
        end
    end

    // Read-owner register; reset discards any outstanding response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_q <= OWNER_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // Response steering; a redirect kills a fetch response in flight.
    always_comb begin
        if_rvalid = (rd_owner_q == OWNER_IF) & ~if_flush;
        d_rvalid  = (rd_owner_q == OWNER_DATA);
        if_rdata  = rst ? '0 : m_rdata;
        d_rdata   = rst ? '0 : m_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: memory device model, per-cycle reference model, and
// directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_clr = 1'b1;
    logic        if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_stall, if_rvalid, d_gnt, d_stall, d_rvalid;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic        m_en, m_we;
    logic [3:0]  m_be;

    logic        u1_if_gnt, u1_if_stall, u1_if_rvalid, u1_d_gnt, u1_d_stall, u1_d_rvalid;
    logic [31:0] u1_if_rdata, u1_d_rdata, u1_m_addr, u1_m_wdata;
    logic        u1_m_en, u1_m_we;
    logic [3:0]  u1_m_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(3)) u0 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_stall(if_stall), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(1)) u1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(u1_if_gnt), .if_stall(u1_if_stall), .if_rvalid(u1_if_rvalid), .if_rdata(u1_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(u1_d_gnt), .d_stall(u1_d_stall), .d_rvalid(u1_d_rvalid), .d_rdata(u1_d_rdata),
        .m_en(u1_m_en), .m_we(u1_m_we), .m_be(u1_m_be), .m_addr(u1_m_addr), .m_wdata(u1_m_wdata),
        .m_rdata(32'h0)
    );

    // Memory device: 256 words, unwritten words hold a pattern derived from the index.
    logic [31:0] mem [256];
    logic        written [256];
    logic [31:0] rd_q;
    assign m_rdata = rd_q;

    function automatic logic [31:0] mem_word(input logic [7:0] idx);
        return written[idx] ? mem[idx] : {8'hC0, idx, 8'h5A, ~idx};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
        end else if (m_en && m_we) begin
            mem[m_addr[9:2]]     <= merge(mem_word(m_addr[9:2]), m_wdata, m_be);
            written[m_addr[9:2]] <= 1'b1;
        end
        if (m_en && !m_we) rd_q <= mem_word(m_addr[9:2]);
    end

    logic any_out;
    assign any_out = if_gnt | if_stall | if_rvalid | d_gnt | d_stall | d_rvalid | m_en | m_we |
                     (|m_be) | (|m_addr) | (|m_wdata) | (|if_rdata) | (|d_rdata);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: IF-waiting data streak and the pending response.
    int          m_streak = 0;
    logic        m_pend_if = 1'b0, m_pend_d = 1'b0;
    logic [31:0] m_exp_if = '0, m_exp_d = '0;
    localparam int MAXS = 3;

    task automatic model_check();
        logic ig, dg;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        if (rst) begin
            chk("rst_outputs", any_out, 0);
            m_streak = 0; m_pend_if = 0; m_pend_d = 0;
            return;
        end
        ig = 0; dg = 0;
        if (d_req && !(if_req && !if_flush && m_streak == MAXS)) dg = 1;
        else if (if_req && !if_flush) ig = 1;
        e_be   = dg ? (d_we ? d_be : 4'hF) : (ig ? 4'hF : 4'h0);
        e_addr = dg ? d_addr : (ig ? if_addr : 32'h0);
        chk("if_gnt", if_gnt, ig);
        chk("d_gnt", d_gnt, dg);
        chk("if_stall", if_stall, if_req && !ig);
        chk("d_stall", d_stall, d_req && !dg);
        chk("m_en", m_en, ig || dg);
        chk("m_we", m_we, dg && d_we);
        chk("m_be", m_be, e_be);
        chk("m_addr", m_addr, e_addr);
        if (dg && d_we) chk("m_wdata", m_wdata, d_wdata);
        chk("if_rvalid", if_rvalid, m_pend_if && !if_flush);
        chk("d_rvalid", d_rvalid, m_pend_d);
        if (m_pend_if && !if_flush) chk("if_rdata", if_rdata, m_exp_if);
        if (m_pend_d) chk("d_rdata", d_rdata, m_exp_d);
        m_pend_if = ig;
        m_exp_if  = mem_word(if_addr[9:2]);
        m_pend_d  = dg && !d_we;
        m_exp_d   = mem_word(d_addr[9:2]);
        if (ig || !if_req) m_streak = 0;
        else if (dg && m_streak < MAXS) m_streak++;
    endtask

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] pat0, pat1;

    initial begin
        if_req = 0; if_flush = 0; d_req = 0; d_we = 0; d_be = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        pat0 = 5'b10111;
        pat1 = 5'b10101;
        #1;
        chk("reset_outputs_t0", any_out, 0);
        adv(); adv();
        tb_clr = 0; rst = 0;
        half(); adv();

        // IF only
        if_req = 1; if_addr = 32'h100;
        half(); chk("if_only_gnt0", if_gnt, 1); adv();
        if_addr = 32'h104;
        half(); chk("if_only_gnt1", if_gnt, 1);
        chk("if_only_rv0", if_rvalid, 1); chk("if_only_rd0", if_rdata, 32'hC0405ABF); adv();
        if_req = 0;
        half(); chk("if_only_rv1", if_rvalid, 1); chk("if_only_rd1", if_rdata, 32'hC0415ABE); adv();

        // Contention: both request loads, compare the two streak limits
        for (int k = 0; k < 5; k++) begin
            if_req = 1; if_addr = 32'h108; d_req = 1; d_we = 0; d_addr = 32'h300 + 32'(4 * k);
            half();
            chk("contend_d_gnt_max3", d_gnt, pat0[k]);
            chk("contend_if_gnt_max3", if_gnt, !pat0[k]);
            chk("alternate_d_gnt_max1", u1_d_gnt, pat1[k]);
            chk("alternate_if_gnt_max1", u1_if_gnt, !pat1[k]);
            adv();
        end
        if_req = 0; d_req = 0;
        half(); adv();

        // Store then read back
        d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 32'h200;
        half(); chk("store_gnt", d_gnt, 1); chk("store_m_we", m_we, 1); chk("store_m_be", m_be, 4'b0011);
        adv();
        d_req = 0; d_we = 0; d_be = 0;
        half(); chk("store_no_rvalid", d_rvalid, 0); adv();
        d_req = 1; d_addr = 32'h200;
        half(); adv();
        d_req = 0;
        half(); chk("load_after_store_rv", d_rvalid, 1);
        chk("load_after_store_lo", d_rdata[15:0], 16'hBEEF);
        chk("load_after_store_word", d_rdata, 32'hC080BEEF); adv();

        // Flush in the response cycle, then re-arbitrate at the new address
        if_req = 1; if_addr = 32'h110;
        half(); chk("flush_gnt_n", if_gnt, 1); adv();
        if_flush = 1; if_addr = 32'h114;
        half(); chk("flush_rvalid", if_rvalid, 0); chk("flush_no_gnt", if_gnt, 0); adv();
        if_flush = 0;
        half(); chk("flush_regnt", if_gnt, 1); chk("flush_regnt_addr", m_addr, 32'h114); adv();
        if_req = 0;
        half(); adv();

        // Flush never affects a data response
        d_req = 1; d_addr = 32'h300;
        half(); adv();
        d_req = 0; if_flush = 1;
        half(); chk("flush_d_rvalid", d_rvalid, 1); chk("flush_d_rdata", d_rdata, 32'hC0C05A3F); adv();
        if_flush = 0;

        // Back-to-back load, IF, load
        d_req = 1; d_addr = 32'h300;
        half(); adv();
        d_req = 0; if_req = 1; if_addr = 32'h104;
        half(); chk("b2b_d_rv0", d_rvalid, 1); chk("b2b_d_rd0", d_rdata, 32'hC0C05A3F); adv();
        if_req = 0; d_req = 1; d_addr = 32'h200;
        half(); chk("b2b_if_rv", if_rvalid, 1); chk("b2b_if_rd", if_rdata, 32'hC0415ABE); adv();
        d_req = 0;
        half(); chk("b2b_d_rv1", d_rvalid, 1); chk("b2b_d_rd1", d_rdata, 32'hC080BEEF); adv();

        // Reset in the middle of a granted load
        d_req = 1; d_addr = 32'h300;
        #1; chk("rstmid_gnt", d_gnt, 1);
        rst = 1;
        #1; chk("rstmid_outputs", any_out, 0);
        d_req = 0;
        half(); adv();
        rst = 0;
        half(); chk("rstmid_no_rvalid", d_rvalid, 0); adv();
        half(); adv();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
